// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 register file and exception/interrupt arbiter at the memory stage.
// Commits precise exception state, runs the Count/Compare timer, and drives flush/redirect.
module cp0_exc_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic        ri_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        ov_i,
    input  logic        eret_i,
    input  logic [31:0] badvaddr_i,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_STATUS   = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;

    localparam logic [4:0] EC_INT  = 5'h00;
    localparam logic [4:0] EC_ADEL = 5'h04;
    localparam logic [4:0] EC_ADES = 5'h05;
    localparam logic [4:0] EC_SYS  = 5'h08;
    localparam logic [4:0] EC_BP   = 5'h09;
    localparam logic [4:0] EC_RI   = 5'h0A;
    localparam logic [4:0] EC_OV   = 5'h0C;

    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic        r_timer_int;
    logic        r_phase;

    logic        w_int_pending;
    logic        w_exc;
    logic [4:0]  w_exccode;
    logic        w_wr;
    logic        w_load_bad;
    logic [31:0] w_epc_next;

    assign w_int_pending = r_status[0] & ~r_status[1]
                         & (|(r_cause[15:8] & r_status[15:8]));

    always_comb begin
        w_exc     = 1'b1;
        w_exccode = EC_INT;
        if (w_int_pending)  w_exccode = EC_INT;
        else if (adel_i)    w_exccode = EC_ADEL;
        else if (ri_i)      w_exccode = EC_RI;
        else if (syscall_i) w_exccode = EC_SYS;
        else if (break_i)   w_exccode = EC_BP;
        else if (ov_i)      w_exccode = EC_OV;
        else if (ades_i)    w_exccode = EC_ADES;
        else                w_exc     = 1'b0;
    end

    assign flush_o    = w_exc | eret_i;
    assign newpc_o    = (!w_exc && eret_i) ? r_epc : EXC_VECTOR;
    // An instruction that traps or returns must not also commit its mtc0.
    assign w_wr       = we_i & ~flush_o;
    assign w_load_bad = w_exc & ((w_exccode == EC_ADEL) | (w_exccode == EC_ADES));
    assign w_epc_next = in_delayslot_i ? (pc_i - 32'd4) : pc_i;

    always_comb begin
        rdata_o = 32'h0;
        case (raddr_i)
            A_BADVADDR: rdata_o = r_badvaddr;
            A_COUNT:    rdata_o = r_count;
            A_COMPARE:  rdata_o = r_compare;
            A_STATUS:   rdata_o = r_status;
            A_CAUSE:    rdata_o = r_cause;
            A_EPC:      rdata_o = r_epc;
            default:    rdata_o = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_badvaddr  <= 32'h0;
            r_count     <= 32'h0;
            r_compare   <= 32'h0;
            r_status    <= STATUS_RST;
            r_cause     <= 32'h0;
            r_epc       <= 32'h0;
            r_timer_int <= 1'b0;
            r_phase     <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (r_phase) r_count <= r_count + 32'd1;
            if ((r_count == r_compare) && (r_compare != 32'h0)) r_timer_int <= 1'b1;
            r_cause[15:10] <= {int_i[5] | r_timer_int, int_i[4:0]};

            if (w_exc) begin
                r_cause[6:2] <= w_exccode;
                r_status[1]  <= 1'b1;
                // Nested exceptions keep the original return point.
                if (!r_status[1]) begin
                    r_epc       <= w_epc_next;
                    r_cause[31] <= in_delayslot_i;
                end
                if (w_load_bad) r_badvaddr <= badvaddr_i;
            end else if (eret_i) begin
                r_status[1] <= 1'b0;
            end

            // Later assignments override the free-running count and timer updates above.
            if (w_wr) begin
                case (waddr_i)
                    A_COUNT: begin
                        r_count <= wdata_i;
                        r_phase <= 1'b0;
                    end
                    A_COMPARE: begin
                        r_compare   <= wdata_i;
                        r_timer_int <= 1'b0;
                    end
                    A_STATUS: begin
                        r_status[15:8] <= wdata_i[15:8];
                        r_status[1:0]  <= wdata_i[1:0];
                    end
                    A_CAUSE: r_cause[9:8] <= wdata_i[9:8];
                    A_EPC:   r_epc        <= wdata_i;
                    default: ;
                endcase
            end
        end
    end

    assign status_o    = r_status;
    assign cause_o     = r_cause;
    assign epc_o       = r_epc;
    assign timer_int_o = r_timer_int;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: a vector table of single-cycle records checked through an
// expected-value queue, plus hand-written timer and mid-operation reset sequences.
module tb_cp0_exc_unit;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam logic [6:0] F_ADEL = 7'b1000000;
  localparam logic [6:0] F_ADES = 7'b0100000;
  localparam logic [6:0] F_RI   = 7'b0010000;
  localparam logic [6:0] F_SYS  = 7'b0001000;
  localparam logic [6:0] F_BRK  = 7'b0000100;
  localparam logic [6:0] F_OV   = 7'b0000010;
  localparam logic [6:0] F_ERET = 7'b0000001;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic        adel_i, ades_i, ri_i, syscall_i, break_i, ov_i, eret_i;
  logic [31:0] badvaddr_i;
  logic        flush_o;
  logic [31:0] newpc_o;
  logic [31:0] status_o, cause_o, epc_o;
  logic        timer_int_o;

  cp0_exc_unit dut (
    .clk(clk), .rst(rst),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o),
    .int_i(int_i), .pc_i(pc_i), .in_delayslot_i(in_delayslot_i),
    .adel_i(adel_i), .ades_i(ades_i), .ri_i(ri_i), .syscall_i(syscall_i),
    .break_i(break_i), .ov_i(ov_i), .eret_i(eret_i),
    .badvaddr_i(badvaddr_i),
    .flush_o(flush_o), .newpc_o(newpc_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .timer_int_o(timer_int_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [5:0]  intr;
    logic [31:0] pc;
    logic        ds;
    logic [6:0]  flags;
    logic [31:0] bad;
    logic        e_flush;
    logic [31:0] e_newpc;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t        tbl[$];
  logic [64:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                     input logic [4:0] raddr, input logic [5:0] intr, input logic [31:0] pc,
                     input logic ds, input logic [6:0] flags, input logic [31:0] bad,
                     input logic e_flush, input logic [31:0] e_newpc, input logic [31:0] e_rdata);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr; v.intr = intr;
    v.pc = pc; v.ds = ds; v.flags = flags; v.bad = bad;
    v.e_flush = e_flush; v.e_newpc = e_newpc; v.e_rdata = e_rdata;
    tbl.push_back(v);
  endtask

  // driver tasks
  task automatic drive_idle();
    we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'h0; raddr_i = 5'd0;
    int_i = 6'd0; pc_i = 32'h0; in_delayslot_i = 1'b0; badvaddr_i = 32'h0;
    {adel_i, ades_i, ri_i, syscall_i, break_i, ov_i, eret_i} = 7'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [64:0] e;
    we_i = v.we; waddr_i = v.waddr; wdata_i = v.wdata; raddr_i = v.raddr;
    int_i = v.intr; pc_i = v.pc; in_delayslot_i = v.ds; badvaddr_i = v.bad;
    {adel_i, ades_i, ri_i, syscall_i, break_i, ov_i, eret_i} = v.flags;
    exp_q.push_back({v.e_flush, v.e_newpc, v.e_rdata});
    #1;
    e = exp_q.pop_front();
    chk($sformatf("v%0d flush", idx), {31'h0, flush_o}, {31'h0, e[64]});
    if (e[64]) chk($sformatf("v%0d newpc", idx), newpc_o, e[63:32]);
    chk($sformatf("v%0d rdata[r%0d]", idx, v.raddr), rdata_o, e[31:0]);
    tick();
  endtask

  initial begin
    // reset and idle: reads of every register, Count advances every second clock
    add(0,0,0, 12,0,0,0,0,0, 0,0,32'h0040_0000);
    add(0,0,0, 13,0,0,0,0,0, 0,0,32'h0);
    add(0,0,0, 14,0,0,0,0,0, 0,0,32'h0);
    add(0,0,0,  8,0,0,0,0,0, 0,0,32'h0);
    add(0,0,0, 11,0,0,0,0,0, 0,0,32'h0);
    add(0,0,0,  5,0,0,0,0,0, 0,0,32'h0);
    add(0,0,0,  9,0,0,0,0,0, 0,0,32'd3);
    add(0,0,0, 12,0,0,0,0,0, 0,0,32'h0040_0000);
    add(0,0,0, 12,0,0,0,0,0, 0,0,32'h0040_0000);
    add(0,0,0, 12,0,0,0,0,0, 0,0,32'h0040_0000);
    add(0,0,0,  9,0,0,0,0,0, 0,0,32'd5);
    // syscall outside a delay slot
    add(0,0,0, 12,0,32'hBFC0_1000,0,F_SYS,0, 1,VEC,32'h0040_0000);
    add(0,0,0, 14,0,0,0,0,0, 0,0,32'hBFC0_1000);
    add(0,0,0, 13,0,0,0,0,0, 0,0,32'h0000_0020);
    add(0,0,0, 12,0,0,0,0,0, 0,0,32'h0040_0002);
    // eret back to EPC
    add(0,0,0, 14,0,0,0,F_ERET,0, 1,32'hBFC0_1000,32'hBFC0_1000);
    // overflow in a delay slot, then break while EXL=1
    add(0,0,0, 12,0,32'hBFC0_2004,1,F_OV,0, 1,VEC,32'h0040_0000);
    add(0,0,0, 14,0,32'h1111_1110,0,F_BRK,0, 1,VEC,32'hBFC0_2000);
    add(0,0,0, 14,0,0,0,0,0, 0,0,32'hBFC0_2000);
    add(0,0,0, 13,0,0,0,0,0, 0,0,32'h8000_0024);
    // enable IM[2]/IE, raise int_i[0]
    add(1,12,32'h0000_0401, 12,0,0,0,0,0, 0,0,32'h0040_0002);
    add(0,0,0, 12,6'b000001,0,0,0,0, 0,0,32'h0040_0401);
    add(0,0,0, 13,6'b000001,32'h0040_0000,0,0,0, 1,VEC,32'h8000_0424);
    add(0,0,0, 13,0,0,0,0,0, 0,0,32'h0000_0400);
    add(0,0,0, 14,0,0,0,0,0, 0,0,32'h0040_0000);
    add(0,0,0, 12,0,0,0,0,0, 0,0,32'h0040_0403);
    // mtc0 EPC suppressed by AdEL in the same cycle
    add(1,14,32'h0000_1234, 8,0,32'hBFC0_3000,0,F_ADEL,32'h8000_0003, 1,VEC,32'h0);
    add(0,0,0,  8,0,0,0,0,0, 0,0,32'h8000_0003);
    add(0,0,0, 14,0,0,0,0,0, 0,0,32'h0040_0000);
    add(0,0,0, 13,0,0,0,0,0, 0,0,32'h0000_0010);
    add(0,0,0, 12,0,0,0,F_ERET,0, 1,32'h0040_0000,32'h0040_0403);
    add(0,0,0, 12,0,0,0,0,0, 0,0,32'h0040_0401);
    // priority: RI over Sys, exception over ERET
    add(0,0,0, 13,0,32'h0000_1000,0,F_RI|F_SYS|F_ERET,0, 1,VEC,32'h0000_0010);
    add(0,0,0, 13,0,0,0,0,0, 0,0,32'h0000_0028);
    add(0,0,0, 14,0,32'h0000_2000,0,F_ADES,32'h0000_0102, 1,VEC,32'h0000_1000);
    add(0,0,0,  8,0,0,0,0,0, 0,0,32'h0000_0102);
    add(0,0,0, 13,0,0,0,0,0, 0,0,32'h0000_0014);
    // Cause only takes IP[1:0]; BadVAddr ignores writes
    add(1,13,32'hFFFF_FFFF, 13,0,0,0,0,0, 0,0,32'h0000_0014);
    add(1,8,32'hDEAD_BEEF, 13,0,0,0,0,0, 0,0,32'h0000_0314);
    add(0,0,0,  8,0,0,0,0,0, 0,0,32'h0000_0102);

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst timer", {31'h0, timer_int_o}, 32'h0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // timer: Compare=4, Count=0, Count reaches 4 after eight clocks
    drive_idle();
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd4;
    tick();
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'd0;
    tick();
    drive_idle();
    raddr_i = 5'd9;
    for (int j = 0; j < 12; j++) begin
      exp_q.push_back({1'b0, 32'h0, 32'(j / 2)});
      #1;
      begin
        logic [64:0] e;
        e = exp_q.pop_front();
        chk($sformatf("timer count c%0d", j), rdata_o, e[31:0]);
      end
      chk($sformatf("timer int c%0d", j), {31'h0, timer_int_o}, (j >= 9) ? 32'd1 : 32'd0);
      if (j == 11) chk("cause ip7 timer", {31'h0, cause_o[15]}, 32'd1);
      tick();
    end
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd100;
    tick();
    drive_idle();
    #1;
    chk("timer clr by compare", {31'h0, timer_int_o}, 32'h0);
    chk("flush idle", {31'h0, flush_o}, 32'h0);

    // asynchronous reset in mid-cycle
    #2;
    syscall_i = 1'b1;
    raddr_i = 5'd9;
    rst = 1'b1;
    #1;
    chk("midrst status", status_o, 32'h0040_0000);
    chk("midrst cause", cause_o, 32'h0);
    chk("midrst epc", epc_o, 32'h0);
    chk("midrst count", rdata_o, 32'h0);
    chk("midrst timer", {31'h0, timer_int_o}, 32'h0);
    chk("midrst flush", {31'h0, flush_o}, 32'd1);
    chk("midrst newpc", newpc_o, VEC);
    syscall_i = 1'b0;
    #1;
    chk("midrst flush off", {31'h0, flush_o}, 32'h0);
    rst = 1'b0;

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
